// File: rtl/spi_memory_param.sv
// SPI slave memory: pin synchronisers, SCLK/CS edge detection, command/data FSM,
// auto-incrementing word address and a tri-stated MISO driver around a synchronous RAM.
module spi_memory_param #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_pin,
    input  logic              cs_pin,
    input  logic              mosi_pin,
    output logic              miso_pin,
    output logic              miso_oe,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam bit CPOL     = ((MODE >> 1) & 1) != 0;
    localparam bit CPHA     = (MODE & 1) != 0;
    localparam int CMD_BITS = ADDR_W + 1;
    localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam int RX_W     = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_READ, S_WRITE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RX_W-1:0]        rx_q, rx_d;
    logic [DATA_W-1:0]      tx_q, tx_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
    logic                   ld1_q, ld1_d;
    logic                   ld2_q, ld2_d;
    logic                   wr_pulse_q, wr_pulse_d;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DATA_W-1:0]      rd_data_q;
    logic                   mem_we;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, addr_in_range;
    logic [ADDR_W-1:0] addr_next;
    logic [RX_W:0]     rx_shift;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise   = ~sclk_prev_q & sclk_s;
        sclk_fall   = sclk_prev_q & ~sclk_s;
        lead_edge   = CPOL ? sclk_fall : sclk_rise;
        trail_edge  = CPOL ? sclk_rise : sclk_fall;
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        cs_fall     = cs_prev_q & ~cs_s;
        cs_rise     = ~cs_prev_q & cs_s;
        rx_shift    = {rx_q, mosi_s};
        // Addresses at or beyond the last implemented word wrap to 0.
        addr_in_range = {1'b0, cur_addr_q} < DEPTH_L;
        addr_next     = ({1'b0, cur_addr_q} >= LAST_L) ? '0 : cur_addr_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        cur_addr_d = cur_addr_q;
        ld1_d      = 1'b0;
        ld2_d      = ld1_q;
        wr_pulse_d = 1'b0;
        mem_we     = 1'b0;

        // Two-cycle load: address settles, RAM reads, then the word enters the shifter.
        if (ld2_q && state_q == S_READ) begin
            tx_d      = rd_data_q;
            miso_oe_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
            end
            S_CMD: begin
                if (sample_edge) begin
                    rx_d  = rx_shift[RX_W-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ADDR_W)) begin
                        cur_addr_d = rx_q[ADDR_W-1:0];
                        cnt_d      = '0;
                        if (mosi_s) begin
                            state_d = S_READ;
                            ld1_d   = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
            end
            S_READ: begin
                if (shift_edge) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = tx_q << 1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d      = '0;
                        cur_addr_d = addr_next;
                        ld1_d      = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (sample_edge) begin
                    rx_d  = rx_shift[RX_W-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d      = '0;
                        cur_addr_d = addr_next;
                        mem_we     = addr_in_range;
                        wr_pulse_d = addr_in_range;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // CS release aborts whatever is in flight, including a partial write word.
        if (cs_rise) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            miso_oe_d  = 1'b0;
            ld1_d      = 1'b0;
            ld2_d      = 1'b0;
            wr_pulse_d = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            cur_addr_q  <= '0;
            ld1_q       <= 1'b0;
            ld2_q       <= 1'b0;
            wr_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            cur_addr_q  <= cur_addr_d;
            ld1_q       <= ld1_d;
            ld2_q       <= ld2_d;
            wr_pulse_q  <= wr_pulse_d;
        end
    end

    // Contents survive reset; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_addr_q] <= rx_shift[DATA_W-1:0];
        end
        rd_data_q <= addr_in_range ? mem[cur_addr_q] : '0;
    end

    assign miso_pin = miso_oe_q ? miso_q : 1'bz;
    assign miso_oe  = miso_oe_q;
    assign busy     = (state_q != S_IDLE);
    assign wr_pulse = wr_pulse_q;
    assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_spi_memory_param.sv
// Directed bench for spi_memory_param: four instances cover modes 0/1/3 and a
// 100-word variant; a bit-level SPI master drives whichever instance is selected.
module tb_spi_memory_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic [3:0] cs_n;
    wire  [3:0] miso_w;
    wire  [3:0] oe_w;
    wire  [3:0] busy_w;
    wire  [3:0] wrp_w;
    wire  [6:0] ca0, ca1, ca2, ca3;

    int         n_checks = 0;
    int         n_errors = 0;
    int         wr_cnt [4] = '{default: 0};
    int         sel = 0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;

    always #5 clk = ~clk;

    spi_memory_param #(.MODE(0), .DEPTH(128)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk), .cs_pin(cs_n[0]), .mosi_pin(mosi),
        .miso_pin(miso_w[0]), .miso_oe(oe_w[0]), .busy(busy_w[0]), .wr_pulse(wrp_w[0]),
        .cur_addr(ca0));

    spi_memory_param #(.MODE(1), .DEPTH(128)) u_m1 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk), .cs_pin(cs_n[1]), .mosi_pin(mosi),
        .miso_pin(miso_w[1]), .miso_oe(oe_w[1]), .busy(busy_w[1]), .wr_pulse(wrp_w[1]),
        .cur_addr(ca1));

    spi_memory_param #(.MODE(3), .DEPTH(128)) u_m3 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk), .cs_pin(cs_n[2]), .mosi_pin(mosi),
        .miso_pin(miso_w[2]), .miso_oe(oe_w[2]), .busy(busy_w[2]), .wr_pulse(wrp_w[2]),
        .cur_addr(ca2));

    spi_memory_param #(.MODE(0), .DEPTH(100)) u_d100 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk), .cs_pin(cs_n[3]), .mosi_pin(mosi),
        .miso_pin(miso_w[3]), .miso_oe(oe_w[3]), .busy(busy_w[3]), .wr_pulse(wrp_w[3]),
        .cur_addr(ca3));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wrp_w[i]) wr_cnt[i] = wr_cnt[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_half();
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        if (!cpha) begin
            mosi = b;
            wait_half();
            sclk = ~cpol;
            r = miso_w[sel];
            wait_half();
            sclk = cpol;
        end else begin
            sclk = ~cpol;
            mosi = b;
            wait_half();
            sclk = cpol;
            r = miso_w[sel];
            wait_half();
        end
    endtask

    task automatic spi_select(input int s, input logic [1:0] m);
        sel  = s;
        cpol = m[1];
        cpha = m[0];
        sclk = cpol;
        mosi = 1'b0;
        wait_half();
        cs_n[sel] = 1'b0;
        wait_half();
    endtask

    task automatic spi_release();
        wait_half();
        cs_n[sel] = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic spi_cmd(input logic [6:0] a, input logic rw);
        logic r;
        for (int i = 6; i >= 0; i--) spi_bit(a[i], r);
        spi_bit(rw, r);
    endtask

    task automatic spi_write_word(input logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) spi_bit(d[i], r);
    endtask

    task automatic spi_read_word(output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(1'b0, r);
            d[i] = r;
        end
    endtask

    logic [7:0] rd;
    logic       dummy;
    int         base;

    initial begin
        rst_n = 1'b0;
        cs_n  = 4'hF;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_busy", {28'd0, busy_w}, 32'h0);
        check_eq("reset_oe", {28'd0, oe_w}, 32'h0);
        check_eq("reset_wr_pulse", {28'd0, wrp_w}, 32'h0);
        check_eq("reset_cur_addr", {25'd0, ca0}, 32'h0);

        // Mode 0 single write then read back
        spi_select(0, 2'd0);
        spi_cmd(7'h12, 1'b0);
        spi_write_word(8'hA5);
        spi_release();
        check_eq("m0_wr_pulse_count", wr_cnt[0], 1);
        check_eq("m0_addr_after_write", {25'd0, ca0}, 32'h13);
        spi_select(0, 2'd0);
        spi_cmd(7'h12, 1'b1);
        spi_read_word(rd);
        spi_release();
        check_eq("m0_read_a5", {24'd0, rd}, 32'hA5);
        check_eq("m0_oe_after_read", {31'd0, oe_w[0]}, 32'h0);

        // Burst write and read across the top of the array
        spi_select(0, 2'd0);
        spi_cmd(7'h7F, 1'b0);
        spi_write_word(8'h11);
        spi_write_word(8'h22);
        spi_write_word(8'h33);
        spi_release();
        check_eq("wrap_wr_pulse_count", wr_cnt[0], 4);
        check_eq("wrap_addr_after_write", {25'd0, ca0}, 32'h02);
        spi_select(0, 2'd0);
        spi_cmd(7'h7F, 1'b1);
        spi_read_word(rd);
        check_eq("wrap_read_7f", {24'd0, rd}, 32'h11);
        spi_read_word(rd);
        check_eq("wrap_read_00", {24'd0, rd}, 32'h22);
        spi_read_word(rd);
        check_eq("wrap_read_01", {24'd0, rd}, 32'h33);
        spi_release();
        check_eq("wrap_addr_after_read", {25'd0, ca0}, 32'h02);

        // Mode 3 and mode 1
        spi_select(2, 2'd3);
        spi_cmd(7'h05, 1'b0);
        spi_write_word(8'h3C);
        spi_release();
        check_eq("m3_oe_after_write", {31'd0, oe_w[2]}, 32'h0);
        spi_select(2, 2'd3);
        spi_cmd(7'h05, 1'b1);
        spi_read_word(rd);
        spi_release();
        check_eq("m3_read_3c", {24'd0, rd}, 32'h3C);
        check_eq("m3_oe_after_read", {31'd0, oe_w[2]}, 32'h0);
        spi_select(1, 2'd1);
        spi_cmd(7'h05, 1'b0);
        spi_write_word(8'h3C);
        spi_release();
        spi_select(1, 2'd1);
        spi_cmd(7'h05, 1'b1);
        spi_read_word(rd);
        spi_release();
        check_eq("m1_read_3c", {24'd0, rd}, 32'h3C);
        check_eq("m1_oe_after_read", {31'd0, oe_w[1]}, 32'h0);
        check_eq("m1_wr_pulse_count", wr_cnt[1], 1);

        // CS abort after 5 data bits
        spi_select(0, 2'd0);
        spi_cmd(7'h20, 1'b0);
        spi_write_word(8'h99);
        spi_release();
        base = wr_cnt[0];
        spi_select(0, 2'd0);
        spi_cmd(7'h20, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(i[0], dummy);
        check_eq("abort_busy_mid", {31'd0, busy_w[0]}, 32'h1);
        spi_release();
        check_eq("abort_no_wr_pulse", wr_cnt[0], base);
        check_eq("abort_oe", {31'd0, oe_w[0]}, 32'h0);
        check_eq("abort_busy", {31'd0, busy_w[0]}, 32'h0);
        spi_select(0, 2'd0);
        spi_cmd(7'h20, 1'b1);
        spi_read_word(rd);
        spi_release();
        check_eq("abort_mem_kept", {24'd0, rd}, 32'h99);

        // Reset during bit 3 of a read
        spi_select(0, 2'd0);
        spi_cmd(7'h12, 1'b1);
        spi_bit(1'b0, dummy);
        spi_bit(1'b0, dummy);
        mosi = 1'b0;
        wait_half();
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_oe_before", {31'd0, oe_w[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_oe", {31'd0, oe_w[0]}, 32'h0);
        check_eq("rst_busy", {31'd0, busy_w[0]}, 32'h0);
        check_eq("rst_cur_addr", {25'd0, ca0}, 32'h0);
        cs_n[0] = 1'b1;
        sclk = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        spi_select(0, 2'd0);
        spi_cmd(7'h12, 1'b1);
        spi_read_word(rd);
        spi_release();
        check_eq("rst_next_read", {24'd0, rd}, 32'hA5);

        // Out of range with DEPTH = 100
        spi_select(3, 2'd0);
        spi_cmd(7'h00, 1'b0);
        spi_write_word(8'h5A);
        spi_release();
        check_eq("oor_setup_wr_pulse", wr_cnt[3], 1);
        spi_select(3, 2'd0);
        spi_cmd(7'h64, 1'b0);
        spi_write_word(8'h77);
        spi_release();
        check_eq("oor_no_wr_pulse", wr_cnt[3], 1);
        check_eq("oor_addr_wraps", {25'd0, ca3}, 32'h0);
        spi_select(3, 2'd0);
        spi_cmd(7'h64, 1'b1);
        spi_read_word(rd);
        check_eq("oor_read_zero", {24'd0, rd}, 32'h00);
        spi_read_word(rd);
        check_eq("oor_next_from_0", {24'd0, rd}, 32'h5A);
        spi_release();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
